pc_fetch: RTL and testbench
===========================

Name: pc_fetch

Overview:
Program counter and fetch sequencer for the picoMIPS core. It sits directly upstream of the combinational program memory and drives its Psize-bit address each cycle. Decoded control from the current instruction selects one of: increment, absolute branch, PC-relative branch, wait-for-external-handshake, or halt. It also synchronises the external "go" switch used by the wait instruction.

Parameters:
Psize, 4, PC/address width; program space is 2^Psize words
RESET_ADDR, 0, PC value loaded on reset (Psize bits)
SYNC_STAGES, 2, flop stages on ext_go (minimum 2)

Ports:
clk  input  1  core clock, rising edge
nReset  input  1  asynchronous, active-low reset
branch_abs  input  1  decoded absolute jump
branch_rel  input  1  decoded PC-relative branch (condition already resolved by decoder)
br_target  input  Psize  absolute target address
br_offset  input  Psize  signed two's-complement offset for branch_rel
wait_req  input  1  decoded wait instruction
wait_level  input  1  level of go_sync that releases the wait
halt_req  input  1  decoded halt instruction
stall  input  1  hold PC this cycle (RUN state only)
ext_go  input  1  asynchronous external switch
address  output  Psize  current PC, drives program memory
running  output  1  high in RUN
waiting  output  1  high in WAIT
halted  output  1  high in HALT
wrap  output  1  one-cycle pulse when a sequential increment wraps from all-ones to 0

Behaviour:
- Reset (async assert, synchronous release at the next edge): address=RESET_ADDR, state=RUN, all sync flops=0, wrap=0. Then running=1, waiting=0, halted=0.
- address is the PC register itself. The program memory is combinational, so the instruction at address is available in the same cycle. Decoded inputs refer to that instruction.
- RUN, per rising edge, with priority highest first:
  - halt_req: PC holds; go to HALT.
  - stall: PC holds; stay in RUN.
  - branch_abs: PC <= br_target.
  - branch_rel: PC <= PC + sext(br_offset), modulo 2^Psize. The base is the address of the branch instruction itself.
  - wait_req: PC holds; latch wait_level; go to WAIT.
  - otherwise: PC <= PC+1, modulo 2^Psize. wrap=1 for the next cycle only if PC was 2^Psize-1.
- wrap is never asserted by branches (including relative wrap-around), holds, or reset.
- WAIT:
  - All decoded inputs and stall are ignored.
  - If go_sync == latched level: PC <= PC+1 (wrap rules as above); go to RUN.
  - Otherwise PC holds.
- HALT: PC holds; all inputs ignored. The only exit is nReset.
- ext_go synchroniser: a SYNC_STAGES-flop chain producing go_sync.
  - With the default of 2, a change on ext_go set up before edge N is visible as go_sync after edge N+1.
  - A WAIT release therefore advances PC at edge N+2.
- Status outputs are decoded from the state register only (no input paths). Exactly one of running/waiting/halted is high at any time.
- Reset asserted in WAIT or HALT returns to RUN at RESET_ADDR. The latched wait_level is cleared to 0.
- No X propagation: an unused state encoding recovers to RUN with PC held.

Decomposition:
- Shared package pc_pkg:
  - typedef enum logic [1:0] pc_state_t {PS_RUN, PS_WAIT, PS_HALT}
  - constant PSIZE_DEFAULT = 4, also shared with the program memory
- Sub-module sync_ff: parameterised flop chain (clk, nReset, d, q), reused for other switch inputs.
- pc_fetch holds the state register, PC register, next-PC mux, and wrap flop.

Test Plan:
1. Reset then 17 idle cycles -> address 0,1,…,15,0. wrap high only in the cycle when address=0 after 15. running=1 throughout.
2. At address=5, branch_rel with br_offset=4'b1101 (-3) -> address=2 next cycle. At address=12, br_offset=7 -> address=3 and wrap=0.
3. At address=4, branch_abs with br_target=9 and branch_rel also asserted -> address=9 (absolute wins). Then stall for 3 cycles -> address stays at 9.
4. At address=6, wait_req with wait_level=1 and ext_go=0 -> waiting=1, address holds at 6 for 10 cycles, with branch_abs toggled and ignored. Set ext_go=1 before edge N -> address=7 and running=1 after edge N+2, not earlier.
5. halt_req together with branch_abs at address=3 -> halted=1, address stays at 3 for 20 cycles. Assert nReset low mid-cycle -> address=0 and running=1 immediately (asynchronous).
6. Reset asserted while in WAIT -> returns to RUN at RESET_ADDR. A second wait with wait_level=0 and ext_go already 0 -> release two edges later.

Source files
------------

// File: rtl/pc_pkg.sv
// Types and constants shared by the picoMIPS fetch path and program memory.
package pc_pkg;

    localparam int PSIZE_DEFAULT = 4;

    typedef enum logic [1:0] {
        PS_RUN  = 2'd0,
        PS_WAIT = 2'd1,
        PS_HALT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/sync_ff.sv
// Flop chain that synchronises an asynchronous switch input into the clk domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nReset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer: next-PC selection, RUN/WAIT/HALT control
// and the wrap pulse for the picoMIPS core.
module pc_fetch
    import pc_pkg::*;
#(
    parameter int               Psize       = PSIZE_DEFAULT,
    parameter logic [Psize-1:0] RESET_ADDR  = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             branch_abs,
    input  logic             branch_rel,
    input  logic [Psize-1:0] br_target,
    input  logic [Psize-1:0] br_offset,
    input  logic             wait_req,
    input  logic             wait_level,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             ext_go,
    output logic [Psize-1:0] address,
    output logic             running,
    output logic             waiting,
    output logic             halted,
    output logic             wrap
);

    localparam logic [1:0] ST_RUN  = PS_RUN;
    localparam logic [1:0] ST_WAIT = PS_WAIT;
    localparam logic [1:0] ST_HALT = PS_HALT;

    logic [1:0]       state, next_state;
    logic [Psize-1:0] pc, next_pc;
    logic             level, next_level;
    logic             next_wrap;
    logic             go_sync;
    logic [Psize-1:0] pc_inc;
    logic             at_top;

    sync_ff #(.STAGES(SYNC_STAGES)) u_go_sync (
        .clk    (clk),
        .nReset (nReset),
        .d      (ext_go),
        .q      (go_sync)
    );

    assign pc_inc = pc + Psize'(1);
    assign at_top = &pc;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        next_level = level;
        next_wrap  = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt_req) begin
                    next_state = ST_HALT;
                end else if (stall) begin
                    next_pc = pc;
                end else if (branch_abs) begin
                    next_pc = br_target;
                end else if (branch_rel) begin
                    // Same-width add is the sign-extended add taken modulo 2^Psize.
                    next_pc = pc + br_offset;
                end else if (wait_req) begin
                    next_level = wait_level;
                    next_state = ST_WAIT;
                end else begin
                    next_pc   = pc_inc;
                    next_wrap = at_top;
                end
            end
            ST_WAIT: begin
                if (go_sync == level) begin
                    next_pc    = pc_inc;
                    next_wrap  = at_top;
                    next_state = ST_RUN;
                end
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= ST_RUN;
            pc    <= RESET_ADDR;
            level <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            level <= next_level;
            wrap  <= next_wrap;
        end
    end

    assign address = pc;
    assign running = (state == ST_RUN);
    assign waiting = (state == ST_WAIT);
    assign halted  = (state == ST_HALT);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch with hand-computed expectations.
module tb_pc_fetch;

    logic       clk;
    logic       nReset;
    logic       branch_abs, branch_rel;
    logic [3:0] br_target, br_offset;
    logic       wait_req, wait_level, halt_req, stall, ext_go;
    logic [3:0] address;
    logic       running, waiting, halted, wrap;

    int checks = 0;
    int errors = 0;

    pc_fetch #(.Psize(4), .RESET_ADDR(4'd0), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .branch_abs (branch_abs),
        .branch_rel (branch_rel),
        .br_target  (br_target),
        .br_offset  (br_offset),
        .wait_req   (wait_req),
        .wait_level (wait_level),
        .halt_req   (halt_req),
        .stall      (stall),
        .ext_go     (ext_go),
        .address    (address),
        .running    (running),
        .waiting    (waiting),
        .halted     (halted),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pc(input string tag, input logic [3:0] exp_addr,
                            input logic [2:0] exp_status, input logic exp_wrap);
        check({tag, ".address"}, address, exp_addr);
        check({tag, ".status"}, {running, waiting, halted}, exp_status);
        check({tag, ".wrap"}, wrap, exp_wrap);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        branch_abs = 0; branch_rel = 0; br_target = 0; br_offset = 0;
        wait_req = 0; wait_level = 0; halt_req = 0; stall = 0;
    endtask

    localparam logic [2:0] RUN  = 3'b100;
    localparam logic [2:0] WAIT = 3'b010;
    localparam logic [2:0] HALT = 3'b001;

    initial begin
        clear_inputs();
        ext_go = 0;
        nReset = 0;
        #2;
        check_pc("reset", 4'd0, RUN, 1'b0);
        #6 nReset = 1;
        check_pc("reset_release", 4'd0, RUN, 1'b0);

        // 1: sequential increment through a full wrap
        for (int i = 1; i <= 16; i++) begin
            step();
            check_pc($sformatf("seq%0d", i), 4'(i), RUN, i == 16);
        end
        step();
        check_pc("seq_after_wrap", 4'd1, RUN, 1'b0);

        // 2: relative branches, backward and forward with wrap-around
        repeat (4) step();
        check_pc("at5", 4'd5, RUN, 1'b0);
        branch_rel = 1; br_offset = 4'b1101;
        step();
        check_pc("rel_minus3", 4'd2, RUN, 1'b0);
        clear_inputs();
        repeat (10) step();
        check_pc("at12", 4'd12, RUN, 1'b0);
        branch_rel = 1; br_offset = 4'd7;
        step();
        check_pc("rel_plus7_wrap", 4'd3, RUN, 1'b0);
        clear_inputs();

        // 3: absolute beats relative, then stall holds
        step();
        check_pc("at4", 4'd4, RUN, 1'b0);
        branch_abs = 1; br_target = 4'd9; branch_rel = 1; br_offset = 4'd1;
        step();
        check_pc("abs_wins", 4'd9, RUN, 1'b0);
        clear_inputs();
        stall = 1; branch_abs = 1; br_target = 4'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pc($sformatf("stall%0d", i), 4'd9, RUN, 1'b0);
        end
        clear_inputs();
        step();
        check_pc("after_stall", 4'd10, RUN, 1'b0);

        // 4: wait for go=1 through the synchroniser
        branch_abs = 1; br_target = 4'd6;
        step();
        check_pc("at6", 4'd6, RUN, 1'b0);
        clear_inputs();
        wait_req = 1; wait_level = 1;
        step();
        check_pc("wait_enter", 4'd6, WAIT, 1'b0);
        for (int i = 0; i < 10; i++) begin
            branch_abs = i[0]; br_target = 4'd13; wait_req = ~i[0]; stall = i[1];
            step();
            check_pc($sformatf("wait_hold%0d", i), 4'd6, WAIT, 1'b0);
        end
        clear_inputs();
        ext_go = 1;
        step();
        check_pc("wait_edgeN", 4'd6, WAIT, 1'b0);
        step();
        check_pc("wait_edgeN1", 4'd6, WAIT, 1'b0);
        step();
        check_pc("wait_release", 4'd7, RUN, 1'b0);
        ext_go = 0;

        // 5: halt beats branch, inputs ignored, async reset exit
        branch_abs = 1; br_target = 4'd3;
        step();
        check_pc("at3", 4'd3, RUN, 1'b0);
        halt_req = 1; br_target = 4'd11;
        step();
        check_pc("halt_enter", 4'd3, HALT, 1'b0);
        for (int i = 0; i < 20; i++) begin
            halt_req = i[0]; branch_abs = i[1]; branch_rel = i[2]; wait_req = i[3];
            br_target = 4'(i); br_offset = 4'd5; ext_go = i[1];
            step();
            check_pc($sformatf("halt_hold%0d", i), 4'd3, HALT, 1'b0);
        end
        clear_inputs();
        ext_go = 0;
        #3 nReset = 0;
        #1;
        check_pc("halt_async_reset", 4'd0, RUN, 1'b0);
        step();
        check_pc("halt_reset_held", 4'd0, RUN, 1'b0);
        nReset = 1;

        // 6: reset from WAIT, then wait for level 0
        step();
        check_pc("at1", 4'd1, RUN, 1'b0);
        wait_req = 1; wait_level = 1;
        step();
        check_pc("wait2_enter", 4'd1, WAIT, 1'b0);
        clear_inputs();
        repeat (2) step();
        check_pc("wait2_hold", 4'd1, WAIT, 1'b0);
        #2 nReset = 0;
        #1;
        check_pc("wait_async_reset", 4'd0, RUN, 1'b0);
        step();
        nReset = 1;
        wait_req = 1; wait_level = 0;
        step();
        check_pc("wait3_enter", 4'd0, WAIT, 1'b0);
        clear_inputs();
        step();
        check_pc("wait3_release", 4'd1, RUN, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
